// File: rtl/fence_flush_sequencer.sv
// Post-commit flush sequencer for fence / fence.i / sfence.vma: data-cache flush
// handshake with bounded wait, then I$/TLB/pipeline pulses, then commit-PC redirect.
module fence_flush_sequencer #(
    parameter logic        DCACHE_FLUSH_EN = 1'b1,
    parameter int unsigned ACK_TIMEOUT     = 1023
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic fence_i,
    input  logic fence_i_i,
    input  logic sfence_vma_i,
    output logic flush_dcache_o,
    input  logic flush_dcache_ack_i,
    output logic flush_icache_o,
    output logic flush_tlb_o,
    output logic flush_pipeline_o,
    output logic set_pc_commit_o,
    output logic halt_o,
    output logic done_o,
    output logic timeout_o
);

    // Width is forced to at least one bit so ACK_TIMEOUT = 0 still elaborates.
    localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DCACHE,
        ST_FLUSH,
        ST_COMMIT
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             need_ic_reg;
    logic             need_tlb_reg;
    logic             flush_dcache_reg;
    logic             flush_icache_reg;
    logic             flush_tlb_reg;
    logic             flush_pipeline_reg;
    logic             set_pc_commit_reg;
    logic             halt_reg;
    logic             done_reg;
    logic             timeout_reg;

    logic req_any;
    logic req_dc;
    logic timeout_hit;

    assign req_any     = fence_i | fence_i_i | sfence_vma_i;
    assign req_dc      = (fence_i | fence_i_i) & DCACHE_FLUSH_EN;
    assign timeout_hit = (ACK_TIMEOUT != 0) && (wait_cnt_reg == CNT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg          <= ST_IDLE;
            wait_cnt_reg       <= '0;
            need_ic_reg        <= 1'b0;
            need_tlb_reg       <= 1'b0;
            flush_dcache_reg   <= 1'b0;
            flush_icache_reg   <= 1'b0;
            flush_tlb_reg      <= 1'b0;
            flush_pipeline_reg <= 1'b0;
            set_pc_commit_reg  <= 1'b0;
            halt_reg           <= 1'b0;
            done_reg           <= 1'b0;
            timeout_reg        <= 1'b0;
        end else begin
            // Single-cycle strobes default low and are raised only on the entering edge.
            flush_icache_reg   <= 1'b0;
            flush_tlb_reg      <= 1'b0;
            flush_pipeline_reg <= 1'b0;
            set_pc_commit_reg  <= 1'b0;
            done_reg           <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (req_any) begin
                        need_ic_reg  <= fence_i_i;
                        need_tlb_reg <= sfence_vma_i;
                        timeout_reg  <= 1'b0;
                        wait_cnt_reg <= '0;
                        halt_reg     <= 1'b1;
                        if (req_dc) begin
                            state_reg        <= ST_DCACHE;
                            flush_dcache_reg <= 1'b1;
                        end else begin
                            state_reg          <= ST_FLUSH;
                            flush_icache_reg   <= fence_i_i;
                            flush_tlb_reg      <= sfence_vma_i;
                            flush_pipeline_reg <= 1'b1;
                        end
                    end
                end

                ST_DCACHE: begin
                    if (wait_cnt_reg != CNT_MAX) begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                    // An ack coinciding with the last wait cycle counts as success.
                    if (flush_dcache_ack_i || timeout_hit) begin
                        state_reg          <= ST_FLUSH;
                        flush_dcache_reg   <= 1'b0;
                        flush_icache_reg   <= need_ic_reg;
                        flush_tlb_reg      <= need_tlb_reg;
                        flush_pipeline_reg <= 1'b1;
                        timeout_reg        <= ~flush_dcache_ack_i;
                    end
                end

                ST_FLUSH: begin
                    state_reg         <= ST_COMMIT;
                    set_pc_commit_reg <= 1'b1;
                    done_reg          <= 1'b1;
                end

                ST_COMMIT: begin
                    state_reg    <= ST_IDLE;
                    halt_reg     <= 1'b0;
                    need_ic_reg  <= 1'b0;
                    need_tlb_reg <= 1'b0;
                end

                default: begin
                    state_reg        <= ST_IDLE;
                    halt_reg         <= 1'b0;
                    flush_dcache_reg <= 1'b0;
                end
            endcase
        end
    end

    assign flush_dcache_o   = flush_dcache_reg;
    assign flush_icache_o   = flush_icache_reg;
    assign flush_tlb_o      = flush_tlb_reg;
    assign flush_pipeline_o = flush_pipeline_reg;
    assign set_pc_commit_o  = set_pc_commit_reg;
    assign halt_o           = halt_reg;
    assign done_o           = done_reg;
    assign timeout_o        = timeout_reg;

endmodule

// File: tb/tb_fence_flush_sequencer.sv
// Bench for fence_flush_sequencer: three configurations (default, ACK_TIMEOUT=8,
// no data-cache step) checked each cycle against a cycle-number timeline model.
module tb_fence_flush_sequencer;

    logic       clk;
    logic       rst;
    logic [2:0] fen, fii, sfv, ack;
    logic [2:0] o_dc, o_ic, o_tlb, o_pl, o_spc, o_halt, o_done, o_to;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        fence_flush_sequencer #(
            .DCACHE_FLUSH_EN((gi == 2) ? 1'b0 : 1'b1),
            .ACK_TIMEOUT    ((gi == 1) ? 8 : 1023)
        ) dut (
            .clk_i             (clk),
            .rst_i             (rst),
            .fence_i           (fen[gi]),
            .fence_i_i         (fii[gi]),
            .sfence_vma_i      (sfv[gi]),
            .flush_dcache_o    (o_dc[gi]),
            .flush_dcache_ack_i(ack[gi]),
            .flush_icache_o    (o_ic[gi]),
            .flush_tlb_o       (o_tlb[gi]),
            .flush_pipeline_o  (o_pl[gi]),
            .set_pc_commit_o   (o_spc[gi]),
            .halt_o            (o_halt[gi]),
            .done_o            (o_done[gi]),
            .timeout_o         (o_to[gi])
        );
    end

    function automatic int to_of(input int k);
        return (k == 1) ? 8 : 1023;
    endfunction

    function automatic bit dcen_of(input int k);
        return (k == 2) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic [7:0] outs(input int k);
        return {o_dc[k], o_ic[k], o_tlb[k], o_pl[k], o_spc[k], o_halt[k], o_done[k], o_to[k]};
    endfunction

    // Model: a sequence is described by its accept cycle and the cycle its
    // data-cache phase ends (ack or timeout); everything else is offsets from that.
    bit         m_act [3];
    bit         m_to  [3];
    bit         m_nic [3];
    bit         m_ntlb[3];
    int         m_acc [3];
    int         m_end [3];
    logic [7:0] m_exp [3];

    always @(posedge clk) begin
        int  y;
        bit  fl, cm, wt;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_act[k] = 1'b0;
                m_to[k]  = 1'b0;
                m_end[k] = -1;
            end else if (m_act[k]) begin
                if (m_end[k] < 0) begin
                    if (ack[k]) begin
                        m_end[k] = cyc;
                    end else if (to_of(k) != 0 && cyc - m_acc[k] == to_of(k)) begin
                        m_end[k] = cyc;
                        m_to[k]  = 1'b1;
                    end
                end else if (cyc == m_end[k] + 2) begin
                    m_act[k] = 1'b0;
                end
            end else if (fen[k] | fii[k] | sfv[k]) begin
                m_act[k]  = 1'b1;
                m_acc[k]  = cyc;
                m_to[k]   = 1'b0;
                m_nic[k]  = fii[k];
                m_ntlb[k] = sfv[k];
                m_end[k]  = ((fen[k] | fii[k]) && dcen_of(k)) ? -1 : cyc;
            end
            y  = cyc + 1;
            wt = m_act[k] && (m_end[k] < 0);
            fl = m_act[k] && (m_end[k] >= 0) && (y == m_end[k] + 1);
            cm = m_act[k] && (m_end[k] >= 0) && (y == m_end[k] + 2);
            m_exp[k] = {wt, fl & m_nic[k], fl & m_ntlb[k], fl, cm, m_act[k], cm, m_to[k]};
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        logic [7:0] want;
        for (int k = 0; k < 3; k++) begin
            want  = rst ? 8'h00 : m_exp[k];
            total = total + 1;
            if (outs(k) !== want) begin
                bad = bad + 1;
                $display("FAIL model_inst%0d cyc=%0d got=%b want=%b (dc ic tlb pl spc halt done to)",
                         k, cyc, outs(k), want);
            end
        end
    end

    task automatic lit(input string name, input logic [7:0] got, input logic [7:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end else begin
            $display("ok   %s = %0h", name, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;
        rst = 1'b1;
        fen = '0; fii = '0; sfv = '0; ack = '0;
        tick(); tick();
        lit("reset_outputs_inst0", outs(0), 8'h00);
        lit("reset_outputs_inst1", outs(1), 8'h00);
        rst = 1'b0;
        tick(); tick();

        // fence.i, ack in cycle 4
        fii[0] = 1'b1; tick(); fii[0] = 1'b0;
        lit("t1_c1_dc", o_dc[0], 1);
        lit("t1_c1_halt", o_halt[0], 1);
        tick(); tick(); tick();
        lit("t1_c4_dc", o_dc[0], 1);
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        lit("t1_c5_ic", o_ic[0], 1);
        lit("t1_c5_pl", o_pl[0], 1);
        lit("t1_c5_tlb", o_tlb[0], 0);
        lit("t1_c5_dc", o_dc[0], 0);
        tick();
        lit("t1_c6_spc", o_spc[0], 1);
        lit("t1_c6_done", o_done[0], 1);
        tick();
        lit("t1_c7_halt", o_halt[0], 0);
        tick();

        // sfence.vma alone
        sfv[0] = 1'b1; tick(); sfv[0] = 1'b0;
        lit("t2_c1_tlb", o_tlb[0], 1);
        lit("t2_c1_pl", o_pl[0], 1);
        lit("t2_c1_dc", o_dc[0], 0);
        tick();
        lit("t2_c2_spc", o_spc[0], 1);
        lit("t2_c2_halt", o_halt[0], 1);
        tick();
        lit("t2_c3_halt", o_halt[0], 0);
        tick();

        // all three requests, ack in cycle 1, requests held through cycle 3
        fen[0] = 1'b1; fii[0] = 1'b1; sfv[0] = 1'b1;
        tick();
        done_cnt = 0;
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        lit("t3_c2_ic", o_ic[0], 1);
        lit("t3_c2_tlb", o_tlb[0], 1);
        done_cnt += o_done[0];
        tick(); done_cnt += o_done[0];
        tick();
        fen[0] = 1'b0; fii[0] = 1'b0; sfv[0] = 1'b0;
        done_cnt += o_done[0];
        lit("t3_c4_halt", o_halt[0], 0);
        tick(); done_cnt += o_done[0];
        tick(); done_cnt += o_done[0];
        lit("t3_done_count", 8'(done_cnt), 1);

        // ACK_TIMEOUT=8 with no ack, stale ack, then clear by next request
        fen[1] = 1'b1; tick(); fen[1] = 1'b0;
        lit("t4_c1_dc", o_dc[1], 1);
        repeat (7) tick();
        lit("t4_c8_dc", o_dc[1], 1);
        lit("t4_c8_to", o_to[1], 0);
        tick();
        lit("t4_c9_dc", o_dc[1], 0);
        lit("t4_c9_pl", o_pl[1], 1);
        lit("t4_c9_to", o_to[1], 1);
        tick();
        ack[1] = 1'b1; tick(); ack[1] = 1'b0;
        lit("t4_c11_halt", o_halt[1], 0);
        lit("t4_c11_to", o_to[1], 1);
        tick();
        lit("t4_c12_to", o_to[1], 1);
        fen[1] = 1'b1; tick(); fen[1] = 1'b0;
        lit("t4_next_to_cleared", o_to[1], 0);
        lit("t4_next_dc", o_dc[1], 1);
        ack[1] = 1'b1; tick(); ack[1] = 1'b0;
        tick(); tick(); tick();

        // ACK_TIMEOUT=8, ack on the timeout cycle
        fen[1] = 1'b1; tick(); fen[1] = 1'b0;
        repeat (7) tick();
        ack[1] = 1'b1; tick(); ack[1] = 1'b0;
        lit("t5_c9_to", o_to[1], 0);
        lit("t5_c9_pl", o_pl[1], 1);
        lit("t5_c9_dc", o_dc[1], 0);
        tick(); tick(); tick();

        // data-cache step disabled
        fii[2] = 1'b1; tick(); fii[2] = 1'b0;
        lit("t6_c1_dc", o_dc[2], 0);
        lit("t6_c1_ic", o_ic[2], 1);
        lit("t6_c1_pl", o_pl[2], 1);
        tick(); tick(); tick();

        // asynchronous reset in cycle 3 of DCACHE
        fen[0] = 1'b1; tick(); fen[0] = 1'b0;
        tick(); tick();
        lit("t7_c3_dc", o_dc[0], 1);
        #2 rst = 1'b1;
        #1;
        lit("t7_rst_dc", o_dc[0], 0);
        lit("t7_rst_halt", o_halt[0], 0);
        tick();
        rst = 1'b0;
        tick();
        lit("t7_post_halt", o_halt[0], 0);
        fen[0] = 1'b1; tick(); fen[0] = 1'b0;
        lit("t7_reaccept_dc", o_dc[0], 1);
        lit("t7_reaccept_halt", o_halt[0], 1);
        ack[0] = 1'b1; tick(); ack[0] = 1'b0;
        tick(); tick();
        lit("t7_end_halt", o_halt[0], 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
